// File: rtl/sys_skew_feeder_if.sv
// DFU-to-feeder beat channel: one K-step per beat (column of A, row of B) with a
// registered ready coming back from the feeder.
interface sys_skew_feeder_if #(
  parameter int ROW = 8,
  parameter int COL = 8,
  parameter int ES  = 8
);
  logic                    dfu2fdr_vld;
  logic                    dfu2fdr_last;
  logic [ROW-1:0][ES-1:0]  dfu2fdr_a_data;
  logic [COL-1:0][ES-1:0]  dfu2fdr_b_data;
  logic                    fdr2dfu_rdy;

  modport master (
    output dfu2fdr_vld,
    output dfu2fdr_last,
    output dfu2fdr_a_data,
    output dfu2fdr_b_data,
    input  fdr2dfu_rdy
  );

  modport slave (
    input  dfu2fdr_vld,
    input  dfu2fdr_last,
    input  dfu2fdr_a_data,
    input  dfu2fdr_b_data,
    output fdr2dfu_rdy
  );
endinterface

// File: rtl/sys_skew_feeder.sv
// Skew staging in front of the systolic array: A lane r delayed r+1 cycles, B lane c
// delayed c+1 cycles, plus per-tile flow control (feed, drain the skew, hold off for C readout).
module sys_skew_feeder #(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int ES      = 8,
  parameter int K_DEPTH = 8,
  parameter int GAP     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sys_skew_feeder_if.slave       dfu_if,
  output logic [ROW-1:0]         dfu2sys_a_data_in_vld_o,
  output logic [ROW-1:0][ES-1:0] dfu2sys_a_data_in_o,
  output logic [COL-1:0]         dfu2sys_b_data_in_vld_o,
  output logic [COL-1:0][ES-1:0] dfu2sys_b_data_in_o,
  output logic                   fdr_busy_o,
  output logic                   fdr_tile_done_o,
  output logic                   fdr_len_err_o
);

  localparam int MAXD = (ROW > COL) ? ROW : COL;
  localparam int CW   = $clog2(K_DEPTH + 1);
  localparam int TMAX = (MAXD > GAP) ? MAXD : GAP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] K_LAST    = CW'(K_DEPTH);
  localparam logic [TW-1:0] DRAIN_END = TW'(MAXD - 1);
  localparam logic [TW-1:0] WAIT_END  = TW'(GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            rdy_q, rdy_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            len_err_q, len_err_d;

  logic            accept_s;
  logic            tile_end_s;
  logic [CW-1:0]   beat_cnt_inc_s;

  // beat_cnt is 0 in IDLE, so the increment also yields 1 for the first beat of a tile
  assign accept_s       = dfu_if.dfu2fdr_vld & rdy_q;
  assign beat_cnt_inc_s = beat_cnt_q + CW'(1);
  assign tile_end_s     = accept_s & (dfu_if.dfu2fdr_last | (beat_cnt_inc_s == K_LAST));

  // next-state, counters and next values of the registered status outputs
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    tmr_d      = tmr_q;
    len_err_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_FEED: begin
        if (accept_s) begin
          beat_cnt_d = beat_cnt_inc_s;
          if (tile_end_s) begin
            state_d    = ST_DRAIN;
            tmr_d      = {TW{1'b0}};
            beat_cnt_d = {CW{1'b0}};
            len_err_d  = dfu_if.dfu2fdr_last ^ (beat_cnt_inc_s == K_LAST);
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (tmr_q == DRAIN_END) begin
          state_d = ST_WAIT;
          tmr_d   = {TW{1'b0}};
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_WAIT: begin
        if (tmr_q == WAIT_END) begin
          state_d    = ST_IDLE;
          tmr_d      = {TW{1'b0}};
          beat_cnt_d = {CW{1'b0}};
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tmr_d      = {TW{1'b0}};
        beat_cnt_d = {CW{1'b0}};
      end
    endcase
    rdy_d  = (state_d == ST_IDLE) || (state_d == ST_FEED);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_WAIT) && (tmr_d == WAIT_END);
  end

  // control state and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= {CW{1'b0}};
      tmr_q      <= {TW{1'b0}};
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      tmr_q      <= tmr_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
    end
  end

  assign dfu_if.fdr2dfu_rdy = rdy_q;
  assign fdr_busy_o         = busy_q;
  assign fdr_tile_done_o    = done_q;
  assign fdr_len_err_o      = len_err_q;

  // A lane r: r+1 stage shift line; non-accepted cycles inject an all-zero bubble
  for (genvar r = 0; r < ROW; r++) begin : g_a_lane
    logic [r:0]         vld_q;
    logic [r:0][ES-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= accept_s;
        dat_q[0] <= accept_s ? dfu_if.dfu2fdr_a_data[r] : {ES{1'b0}};
        for (int j = 1; j <= r; j++) begin
          vld_q[j] <= vld_q[j-1];
          dat_q[j] <= dat_q[j-1];
        end
      end
    end

    assign dfu2sys_a_data_in_vld_o[r] = vld_q[r];
    assign dfu2sys_a_data_in_o[r]     = dat_q[r];
  end

  // B lane c: c+1 stage shift line, same bubble injection as the A lanes
  for (genvar c = 0; c < COL; c++) begin : g_b_lane
    logic [c:0]         vld_q;
    logic [c:0][ES-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q[0] <= accept_s;
        dat_q[0] <= accept_s ? dfu_if.dfu2fdr_b_data[c] : {ES{1'b0}};
        for (int j = 1; j <= c; j++) begin
          vld_q[j] <= vld_q[j-1];
          dat_q[j] <= dat_q[j-1];
        end
      end
    end

    assign dfu2sys_b_data_in_vld_o[c] = vld_q[c];
    assign dfu2sys_b_data_in_o[c]     = dat_q[c];
  end

endmodule

// File: tb/tb_sys_skew_feeder.sv
// Bench for sys_skew_feeder: directed and random beat streams checked every cycle
// against a timeline model (accept history, tile end, hold-off window).
module tb_sys_skew_feeder;
  localparam int ROW     = 8;
  localparam int COL     = 8;
  localparam int ES      = 8;
  localparam int K_DEPTH = 8;
  localparam int GAP     = 10;
  localparam int MAXD    = (ROW > COL) ? ROW : COL;
  localparam int RING    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ROW-1:0]         a_vld;
  logic [ROW-1:0][ES-1:0] a_dat;
  logic [COL-1:0]         b_vld;
  logic [COL-1:0][ES-1:0] b_dat;
  logic busy, done, lerr;

  sys_skew_feeder_if #(.ROW(ROW), .COL(COL), .ES(ES)) bus ();

  sys_skew_feeder #(.ROW(ROW), .COL(COL), .ES(ES), .K_DEPTH(K_DEPTH), .GAP(GAP)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .dfu_if                  (bus),
    .dfu2sys_a_data_in_vld_o (a_vld),
    .dfu2sys_a_data_in_o     (a_dat),
    .dfu2sys_b_data_in_vld_o (b_vld),
    .dfu2sys_b_data_in_o     (b_dat),
    .fdr_busy_o              (busy),
    .fdr_tile_done_o         (done),
    .fdr_len_err_o           (lerr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // model: what was accepted in each cycle, and the tile timeline
  logic                 hist_v [RING];
  logic [ROW*ES-1:0]    hist_a [RING];
  logic [COL*ES-1:0]    hist_b [RING];
  int cyc, block_end, done_at, err_at, tcnt;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < RING; i++) begin
      hist_v[i] = 1'b0;
      hist_a[i] = '0;
      hist_b[i] = '0;
    end
    cyc = 0; block_end = -1; done_at = -1000; err_at = -1000; tcnt = 0;
  endtask

  task automatic check_outputs();
    logic [ROW-1:0]    ev_a;
    logic [ROW*ES-1:0] ed_a;
    logic [COL-1:0]    ev_b;
    logic [COL*ES-1:0] ed_b;
    int src;
    ev_a = '0; ed_a = '0; ev_b = '0; ed_b = '0;
    for (int r = 0; r < ROW; r++) begin
      src = cyc - 1 - r;
      if (src >= 0 && hist_v[src % RING]) begin
        ev_a[r] = 1'b1;
        ed_a[r*ES +: ES] = hist_a[src % RING][r*ES +: ES];
      end
    end
    for (int c = 0; c < COL; c++) begin
      src = cyc - 1 - c;
      if (src >= 0 && hist_v[src % RING]) begin
        ev_b[c] = 1'b1;
        ed_b[c*ES +: ES] = hist_b[src % RING][c*ES +: ES];
      end
    end
    chk_eq("a_vld", a_vld, ev_a);
    chk_eq("a_data", a_dat, ed_a);
    chk_eq("b_vld", b_vld, ev_b);
    chk_eq("b_data", b_dat, ed_b);
    chk_eq("tile_done", done, cyc == done_at);
    chk_eq("len_err", lerr, cyc == err_at);
    chk_eq("busy", busy, (tcnt != 0) || (cyc <= block_end));
  endtask

  task automatic zero_check(input string tag);
    chk_eq({tag, "_rdy"}, bus.fdr2dfu_rdy, 1'b0);
    chk_eq({tag, "_vld"}, {a_vld, b_vld}, '0);
    chk_eq({tag, "_data"}, {a_dat, b_dat}, '0);
    chk_eq({tag, "_status"}, {busy, done, lerr}, '0);
  endtask

  task automatic do_reset();
    bus.dfu2fdr_vld = 1'b0; bus.dfu2fdr_last = 1'b0;
    bus.dfu2fdr_a_data = '0; bus.dfu2fdr_b_data = '0;
    rst_n = 1'b0;
    #1;
    zero_check("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_model();
    check_outputs();
  endtask

  // one clock cycle: drive, predict acceptance, advance, check the new cycle
  task automatic step(input logic v, input logic l, input logic [ROW*ES-1:0] a,
                      input logic [COL*ES-1:0] b, output logic acc);
    logic exp_rdy;
    exp_rdy = (cyc > block_end);
    bus.dfu2fdr_vld = v; bus.dfu2fdr_last = l;
    bus.dfu2fdr_a_data = a; bus.dfu2fdr_b_data = b;
    chk_eq("rdy", bus.fdr2dfu_rdy, exp_rdy);
    acc = v && exp_rdy;
    hist_v[cyc % RING] = acc;
    hist_a[cyc % RING] = acc ? a : '0;
    hist_b[cyc % RING] = acc ? b : '0;
    if (acc) begin
      tcnt++;
      if (l || tcnt == K_DEPTH) begin
        if (l != (tcnt == K_DEPTH)) err_at = cyc + 1;
        done_at = cyc + MAXD + GAP;
        block_end = done_at;
        tcnt = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, acc);
  endtask

  // n beats; last_idx<0 means no last flag; bub_at inserts one bubble before that beat
  task automatic send_beats(input int n, input int last_idx, input int bub_pct,
                            input int bub_at, input bit rnd);
    logic [ROW*ES-1:0] a, ja;
    logic [COL*ES-1:0] b, jb;
    logic acc;
    int tries;
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < ROW; r++) begin
        a[r*ES +: ES]  = rnd ? ES'($urandom) : ES'(16*k + r);
        ja[r*ES +: ES] = ES'($urandom);
      end
      for (int c = 0; c < COL; c++) begin
        b[c*ES +: ES]  = rnd ? ES'($urandom) : ES'(16*k + c + 8);
        jb[c*ES +: ES] = ES'($urandom);
      end
      if (k == bub_at) step(1'b0, 1'b1, ja, jb, acc);
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 64) begin
        if ($urandom_range(0, 99) < bub_pct) step(1'b0, 1'b1, ja, jb, acc);
        else step(1'b1, k == last_idx, a, b, acc);
        tries++;
      end
      if (!acc) chk_eq("beat_accept_budget", 1'b0, 1'b1);
    end
  endtask

  initial begin
    int n, li;
    do_reset();
    // back-to-back 8-beat tile, then with a bubble after beat 3
    send_beats(8, 7, 0, -1, 1'b0);
    idle(30);
    send_beats(8, 7, 0, 4, 1'b0);
    idle(30);
    // short tile, next tile offered immediately (vld held through drain/wait)
    send_beats(6, 5, 0, -1, 1'b0);
    send_beats(8, 7, 0, -1, 1'b0);
    idle(30);
    send_beats(8, 7, 0, -1, 1'b0);
    send_beats(8, 7, 0, -1, 1'b0);
    idle(30);
    // reset in the middle of a tile, then a clean tile
    send_beats(4, -1, 0, -1, 1'b0);
    rst_n = 1'b0;
    #1;
    zero_check("midreset");
    do_reset();
    send_beats(8, 7, 0, -1, 1'b0);
    idle(30);
    // tile closed by the beat count without last, then a single-beat tile
    send_beats(8, -1, 0, -1, 1'b1);
    send_beats(1, 0, 0, -1, 1'b1);
    idle(30);
    for (int t = 0; t < 25; t++) begin
      n  = $urandom_range(1, 12);
      li = $urandom_range(0, n);
      send_beats(n, (li == n) ? -1 : li, 20, -1, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
    end
    idle(40);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
